// File: rtl/booth_radix4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier.
// Two multiplier bits are retired per cycle. The selected partial product
// (0, +-M, +-2M) is added into an N+2 bit accumulator by a ripple adder.
// A negative digit is formed as ~addend with carry-in 1.

// Plain ripple adder; the carry-out is exposed but may be ignored by callers.
module full_adder #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  input  logic         Carry_i,
  output logic [W-1:0] Sum_o,
  output logic         Carry_o
);

  // Sum with carry-in, one extra bit to capture the carry-out.
  assign {Carry_o, Sum_o} = {1'b0, A_i} + {1'b0, B_i} + {{W{1'b0}}, Carry_i};

endmodule

module booth_radix4_seq_mult #(
  parameter int unsigned N = 8
) (
  input  logic           Clk_i,
  input  logic           Rst_i,
  input  logic           Start_i,
  input  logic [N-1:0]   Multiplicand_i,
  input  logic [N-1:0]   Multiplier_i,
  output logic           Busy_o,
  output logic           Done_o,
  output logic [2*N-1:0] Product_o
);

  localparam int unsigned AW   = N + 2;
  localparam int unsigned ITER = N / 2;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    mx_q;
  logic [AW-1:0]    acc_q;
  logic [N-1:0]     qr_q;
  logic             q_m1_q;
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   product_q;

  logic [AW-1:0]    addend;
  logic             negate;
  logic [AW-1:0]    sum;
  logic             adder_carry_unused;
  logic [2*N+2:0]   shifted;
  logic             accept;
  logic             last_iter;

  assign accept    = Start_i && (state_q != S_CALC);
  assign last_iter = (state_q == S_CALC) && (cnt_q == LAST);

  // {Sum, Qr, q_m1} arithmetic-shifted right by 2; the dropped bits are
  // q_m1 and Qr[0], so the new q_m1 is the old Qr[1].
  assign shifted = {sum[AW-1], sum[AW-1], sum, qr_q[N-1:1]};

  // State register.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: start accepted from IDLE or DONE, ignored in CALC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start_i) state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = Start_i ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Booth digit recode from {Qr[1], Qr[0], q_m1} into the adder's B input.
  always_comb begin
    addend = '0;
    negate = 1'b0;
    case ({qr_q[1:0], q_m1_q})
      3'b001, 3'b010: addend = mx_q;
      3'b011:         addend = {mx_q[AW-2:0], 1'b0};
      3'b100: begin
        addend = ~{mx_q[AW-2:0], 1'b0};
        negate = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = ~mx_q;
        negate = 1'b1;
      end
      default:        addend = '0;
    endcase
  end

  full_adder #(.W(AW)) u_adder (
    .A_i     (acc_q),
    .B_i     (addend),
    .Carry_i (negate),
    .Sum_o   (sum),
    .Carry_o (adder_carry_unused)
  );

  // Operand load on accept, one Booth step per CALC cycle, product capture on the last step.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      mx_q      <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      q_m1_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mx_q   <= {{2{Multiplicand_i[N-1]}}, Multiplicand_i};
      acc_q  <= '0;
      qr_q   <= Multiplier_i;
      q_m1_q <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == S_CALC) begin
      acc_q  <= shifted[2*N+2:N+1];
      qr_q   <= shifted[N:1];
      q_m1_q <= shifted[0];
      cnt_q  <= cnt_q + CW'(1);
      if (last_iter) product_q <= shifted[2*N:1];
    end
  end

  assign Busy_o    = (state_q == S_CALC);
  assign Done_o    = (state_q == S_DONE);
  assign Product_o = product_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench for booth_radix4_seq_mult (N=8): directed corner cases,
// back-to-back accept, start-while-busy, mid-operation reset, random operands.
module tb_booth_radix4_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests;
  int fails;
  int done_cnt;
  int exp_done;

  booth_radix4_seq_mult #(.N(8)) dut (
    .Clk_i          (clk),
    .Rst_i          (rst),
    .Start_i        (start),
    .Multiplicand_i (mcand),
    .Multiplier_i   (mplier),
    .Busy_o         (busy),
    .Done_o         (done),
    .Product_o      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which Done_o is high.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int r;
    r = int'($signed(m)) * int'($signed(q));
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Launch one operation; returns at #1 after the edge that raises Done_o.
  task automatic do_mult(input logic [7:0] m, input logic [7:0] q,
                         output logic [15:0] p, output int lat);
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mcand  = 8'($urandom);
    mplier = 8'($urandom);
    exp_done++;
    wait_done(lat);
    p = product;
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  m, q;
    int          lat;
    logic [7:0]  corners [6];

    tests = 0; fails = 0; done_cnt = 0; exp_done = 0;
    corners = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F};
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // 3*5: busy from the accept edge, done exactly 4 cycles later, one-cycle pulse.
    mcand = 8'd3; mplier = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_done++;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("latency_3x5", lat, 32'd4);
    check("product_3x5", {16'd0, product}, 32'h000F);
    @(posedge clk); #1;
    check("done_pulse_low", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("product_held", {16'd0, product}, 32'h000F);

    do_mult(8'h80, 8'h80, p, lat);
    check("m128_m128", {16'd0, p}, 32'h4000);
    do_mult(8'h80, 8'h7F, p, lat);
    check("m128_p127", {16'd0, p}, 32'hC080);
    do_mult(8'hFF, 8'hFF, p, lat);
    check("m1_m1", {16'd0, p}, 32'h0001);
    do_mult(8'h00, 8'hB3, p, lat);
    check("zero_m77", {16'd0, p}, 32'h0000);

    // Start raised while busy with other operands must be ignored.
    @(posedge clk); #1;
    @(posedge clk); #1;
    mcand = 8'd9; mplier = 8'hF9; start = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    mcand = 8'd100; mplier = 8'd100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("busy_start_ignored", {16'd0, product}, {16'd0, ref_mul(8'd9, 8'hF9)});
    @(posedge clk); #1;
    check("no_extra_done", {31'd0, done}, 32'd0);

    // Back-to-back: start held in the DONE cycle.
    do_mult(8'd10, 8'hFD, p, lat);
    check("b2b_first", {16'd0, p}, {16'd0, ref_mul(8'd10, 8'hFD)});
    mcand = 8'd7; mplier = 8'hFE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_done++;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_latency", lat, 32'd4);
    check("b2b_product", {16'd0, product}, 32'hFFF2);

    // Reset in the middle of an operation.
    mcand = 8'd5; mplier = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_mult(8'hFA, 8'd11, p, lat);
    check("after_reset", {16'd0, p}, {16'd0, ref_mul(8'hFA, 8'd11)});

    // All pairs of signed corner values.
    foreach (corners[i]) begin
      foreach (corners[j]) begin
        do_mult(corners[i], corners[j], p, lat);
        check("corner", {16'd0, p}, {16'd0, ref_mul(corners[i], corners[j])});
      end
    end

    // Random operands, with occasional idle gaps between operations.
    for (int k = 0; k < 1500; k++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      do_mult(m, q, p, lat);
      check("random", {16'd0, p}, {16'd0, ref_mul(m, q)});
      if (k % 100 == 0) check("random_latency", lat, 32'd4);
    end

    repeat (4) @(posedge clk);
    #1;
    check("done_count", done_cnt, exp_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
